// File: rtl/alu_src_pipe.sv
// Registered ALU operand-source selector with a 2-entry skid buffer.
// Optional sticky out-of-range flag: define ALU_SRC_ERR_EN.
module alu_src_pipe #(
   parameter int               WIDTH     = 32,
   parameter int               NUM_SRC   = 8,
   parameter int               SEL_W     = 3,
   parameter int               CONST_IDX = 1,
   parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(4)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_SRC*WIDTH-1:0] src_bus,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         data_out,
   output logic [SEL_W-1:0]         sel_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
   } entry_t;

   state_t state_q, state_d;
   entry_t head_q, skid_q, new_entry;
   logic   [WIDTH-1:0] sel_word;
   logic   accept, drain;
   logic   head_new, head_skid, skid_ld;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign data_out  = head_q.data;
   assign sel_out   = head_q.sel;
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   // Out-of-range selects fall through to the zero default.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (32'(sel) == i) sel_word = src_bus[i*WIDTH +: WIDTH];
      end
      if (sel == SEL_W'(CONST_IDX)) sel_word = CONST_VAL;
   end

   assign new_entry = '{data: sel_word, sel: sel};

   always_comb begin
      state_d   = state_q;
      head_new  = 1'b0;
      head_skid = 1'b0;
      skid_ld   = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d  = ONE;
               head_new = 1'b1;
            end
         end
         ONE: begin
            if (accept && drain) begin
               head_new = 1'b1;
            end else if (accept) begin
               state_d = FULL;
               skid_ld = 1'b1;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               state_d   = ONE;
               head_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         if (head_new)       head_q <= new_entry;
         else if (head_skid) head_q <= skid_q;
         if (skid_ld)        skid_q <= new_entry;
      end
   end

`ifdef ALU_SRC_ERR_EN
   logic err_q;
   logic sel_oor;

   assign sel_oor = (32'(sel) >= NUM_SRC);
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (!reset_n)              err_q <= 1'b0;
      else if (accept && sel_oor) err_q <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule
